// File: rtl/oppm_tx_pkg.sv
// Shared types, default widths and checksum helper for the OPPM transmit framer.
package oppm_tx_pkg;

  localparam int unsigned DEF_PAYLOAD_W = 20;
  localparam int unsigned DEF_SEQ_W     = 4;
  localparam int unsigned DEF_CHK_W     = 8;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_GAP_CT    = 8;
  localparam int unsigned MAX_HDR_W     = 64;
  localparam int unsigned MAX_CHK_W     = 32;

  typedef enum logic [1:0] {IDLE, LAUNCH_WAIT, BUSY, GAP} tx_state_e;

  // Header bit i lands on checksum bit (i mod chk_w): the XOR of all chk_w-wide slices.
  function automatic logic [MAX_CHK_W-1:0] xor_fold(input logic [MAX_HDR_W-1:0] hdr,
                                                    input int unsigned          hdr_w,
                                                    input int unsigned          chk_w);
    logic [MAX_CHK_W-1:0] chk;
    chk = '0;
    for (int unsigned i = 0; i < MAX_HDR_W; i++) begin
      if (i < hdr_w) chk[5'(i % chk_w)] = chk[5'(i % chk_w)] ^ hdr[6'(i)];
    end
    return chk;
  endfunction

endpackage

// File: rtl/oppm_tx_fifo.sv
// Payload FIFO with synchronous clear; the head entry is presented combinationally.
module oppm_tx_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          do_push, do_pop;

  assign full  = (fill_q == FW'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full & ~clear;
    do_pop   = pop & ~empty & ~clear;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      fill_d = fill_q + FW'(do_push) - FW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/oppm_tx_framer.sv
// Frames buffered payload words as {seq, payload, checksum} and launches them into the OPPM Encoder.
module oppm_tx_framer
  import oppm_tx_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned SEQ_W     = DEF_SEQ_W,
  parameter int unsigned CHK_W     = DEF_CHK_W,
  parameter int unsigned N_PKT     = SEQ_W + PAYLOAD_W + CHK_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned GAP_CT    = DEF_GAP_CT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PAYLOAD_W-1:0]       payload,
  input  logic                       payload_valid,
  output logic                       payload_ready,
  input  logic                       flush,
  output logic [N_PKT-1:0]           enc_data,
  output logic                       enc_start,
  input  logic                       enc_avail,
  output logic                       pkt_sent,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned HDR_W = SEQ_W + PAYLOAD_W;
  localparam int unsigned GW    = (GAP_CT > 1) ? $clog2(GAP_CT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CT > 0) ? GAP_CT - 1 : 0);

  if ((HDR_W % CHK_W) != 0) begin : g_bad_chk_w
    $fatal(1, "oppm_tx_framer: SEQ_W+PAYLOAD_W must be a multiple of CHK_W");
  end
  if (N_PKT != HDR_W + CHK_W) begin : g_bad_n_pkt
    $fatal(1, "oppm_tx_framer: N_PKT must equal SEQ_W+PAYLOAD_W+CHK_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "oppm_tx_framer: DEPTH must be a power of two >= 2");
  end
  if ((HDR_W > MAX_HDR_W) || (CHK_W > MAX_CHK_W)) begin : g_bad_width
    $fatal(1, "oppm_tx_framer: header or checksum wider than xor_fold supports");
  end

  tx_state_e            state_q, state_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [PAYLOAD_W-1:0] head;
  logic                 full, empty;
  logic [HDR_W-1:0]     hdr;
  logic [CHK_W-1:0]     chk;

  oppm_tx_fifo #(
    .W     (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (payload_valid & payload_ready),
    .pop   (enc_start),
    .clear (flush),
    .wdata (payload),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign payload_ready = ~full & ~flush;

  // Frame is valid in the same cycle as enc_start since the Encoder loads on start.
  assign hdr      = {seq_q, head};
  assign chk      = CHK_W'(xor_fold(MAX_HDR_W'(hdr), HDR_W, CHK_W));
  assign enc_data = empty ? '0 : {hdr, chk};

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    enc_start = 1'b0;
    pkt_sent  = 1'b0;
    if (flush) seq_d = '0;
    unique case (state_q)
      IDLE: begin
        if (~empty & enc_avail & ~flush) begin
          enc_start = 1'b1;
          seq_d     = seq_q + 1'b1;
          state_d   = LAUNCH_WAIT;
        end
      end
      LAUNCH_WAIT: begin
        if (!enc_avail) state_d = BUSY;
      end
      BUSY: begin
        if (enc_avail) begin
          pkt_sent = 1'b1;
          gap_d    = '0;
          state_d  = (GAP_CT == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_oppm_tx_framer.sv
// Self-checking bench for oppm_tx_framer: behavioural frame/queue model plus directed literal checks.
module tb_oppm_tx_framer;

  localparam int unsigned DEPTH = 4;
  localparam int          GAP   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, payload_valid, payload_ready, flush;
  logic [19:0] payload;
  logic [31:0] enc_data;
  logic        enc_start, enc_avail, pkt_sent;
  logic [2:0]  fill;

  oppm_tx_framer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .payload       (payload),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .flush         (flush),
    .enc_data      (enc_data),
    .enc_start     (enc_start),
    .enc_avail     (enc_avail),
    .pkt_sent      (pkt_sent),
    .fill          (fill)
  );

  logic        rst2_n, valid2, ready2, flush2, start2, avail2, sent2;
  logic [19:0] payload2;
  logic [31:0] data2;
  logic [2:0]  fill2;

  oppm_tx_framer #(.GAP_CT(0)) u_dut_g0 (
    .clk           (clk),
    .rst_n         (rst2_n),
    .payload       (payload2),
    .payload_valid (valid2),
    .payload_ready (ready2),
    .flush         (flush2),
    .enc_data      (data2),
    .enc_start     (start2),
    .enc_avail     (avail2),
    .pkt_sent      (sent2),
    .fill          (fill2)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Frame = {seq, payload, XOR of the three header bytes}.
  function automatic logic [31:0] mk_frame(input int s, input logic [19:0] p);
    logic [23:0] h;
    h = {4'(s % 16), p};
    return {h, h[23:16] ^ h[15:8] ^ h[7:0]};
  endfunction

  // Encoder stand-in: avail drops for enc_len cycles after each start.
  int enc_len  = 3;
  bit enc_hold = 1'b0;
  initial begin
    int busy;
    bit st, rs;
    busy = 0;
    enc_avail = 1'b1;
    forever begin
      @(negedge clk);
      st = enc_start;
      rs = rst_n;
      @(posedge clk);
      #1;
      if (!rs) busy = 0;
      else if (st) busy = enc_len;
      else if (busy > 0) busy--;
      enc_avail = (busy == 0) && !enc_hold;
    end
  end

  // Reference model: queue of payloads, sequence number, in-flight/gap timing.
  logic [19:0] mq[$];
  int mseq      = 0;
  bit in_flight = 1'b0;
  bit saw_low   = 1'b0;
  int ready_at  = 0;

  initial forever begin
    int n;
    logic exp_start, exp_sent, exp_ready;
    logic [31:0] exp_data;
    @(negedge clk);
    if (!rst_n) begin
      mq.delete();
      mseq = 0; in_flight = 1'b0; saw_low = 1'b0; ready_at = 0;
    end
    n         = mq.size();
    exp_ready = (n < DEPTH) && !flush;
    exp_data  = (n > 0) ? mk_frame(mseq, mq[0]) : 32'h0;
    exp_start = rst_n && !in_flight && (cyc >= ready_at) && (n > 0) && enc_avail && !flush;
    exp_sent  = rst_n && in_flight && saw_low && enc_avail;
    check("m_fill",  32'(fill),          32'(n));
    check("m_ready", 32'(payload_ready), 32'(exp_ready));
    check("m_data",  enc_data,           exp_data);
    check("m_start", 32'(enc_start),     32'(exp_start));
    check("m_sent",  32'(pkt_sent),      32'(exp_sent));
    if (rst_n) begin
      if (flush) begin
        mq.delete();
        mseq = 0;
      end else begin
        if (exp_start) begin
          void'(mq.pop_front());
          mseq = (mseq + 1) % 16;
        end
        if (payload_valid && exp_ready) mq.push_back(payload);
      end
      if (exp_start) begin
        in_flight = 1'b1;
        saw_low   = 1'b0;
      end else if (exp_sent) begin
        in_flight = 1'b0;
        ready_at  = cyc + GAP + 1;
      end else if (in_flight && !enc_avail) begin
        saw_low = 1'b1;
      end
    end
  end

  // which: 0 = enc_start, 1 = pkt_sent, 2 = payload_ready; n = cycles waited, 0 on timeout.
  task automatic wait_sig(input int which, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((which == 0 && enc_start) || (which == 1 && pkt_sent) || (which == 2 && payload_ready)) begin
        n = i;
        break;
      end
    end
    tests++;
    if (n == 0) begin
      fails++;
      $display("FAIL wait_%0d: got no event in %0d cycles, required one", which, max);
    end
  endtask

  task automatic push_word(input logic [19:0] w);
    int n;
    @(posedge clk); #1;
    payload = w;
    payload_valid = 1'b1;
    wait_sig(2, 50, n);
    @(posedge clk); #1;
    payload_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s1, ts;
    rst_n = 1'b0; payload_valid = 1'b0; payload = '0; flush = 1'b0;
    rst2_n = 1'b0; valid2 = 1'b0; payload2 = '0; flush2 = 1'b0; avail2 = 1'b1;
    enc_len = 50;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fill",  32'(fill),          32'd0);
    check("rst_ready", 32'(payload_ready), 32'd1);
    check("rst_data",  enc_data,           32'h0);
    check("rst_start", 32'(enc_start),     32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single frame and back-to-back spacing
    push_word(20'h12345);
    wait_sig(0, 5, n);
    check("first_latency", 32'(n), 32'd1);
    check("frame0_data", enc_data, 32'h01234567);
    s1 = cyc;
    push_word(20'h12345);
    wait_sig(1, 100, n);
    ts = cyc;
    wait_sig(0, 40, n);
    check("frame1_data", enc_data, 32'h11234577);
    check("start_spacing", 32'(cyc - s1), 32'd60);
    check("sent_to_start", 32'(cyc - ts), 32'd9);

    // full FIFO with encoder unavailable
    wait_sig(1, 100, n);
    repeat (GAP + 2) @(negedge clk);
    enc_len = 2;
    enc_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_word(20'hA0000 + 20'(i));
    payload = 20'hA0004;
    payload_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_fill",  32'(fill),          32'd4);
    check("full_ready", 32'(payload_ready), 32'd0);
    enc_hold = 1'b0;
    wait_sig(2, 20, n);
    @(posedge clk); #1 payload_valid = 1'b0;
    @(negedge clk);
    check("refill", 32'(fill), 32'd4);

    // sequence wrap
    enc_len = 3;
    pulse_flush();
    for (int i = 0; i < 17; i++) begin
      push_word(20'hABCDE);
      wait_sig(0, 60, n);
      if (i == 15) check("wrap_seqF", enc_data, 32'hFABCDE98);
      if (i == 16) check("wrap_seq0", enc_data, 32'h0ABCDE68);
    end

    // flush while BUSY
    wait_sig(1, 30, n);
    repeat (GAP + 2) @(negedge clk);
    enc_len = 40;
    for (int i = 0; i < 4; i++) push_word(20'h00100 + 20'(i));
    repeat (2) @(negedge clk);
    check("busy_fill3", 32'(fill), 32'd3);
    pulse_flush();
    @(negedge clk);
    check("flush_fill0", 32'(fill), 32'd0);
    wait_sig(1, 60, n);
    enc_len = 8;
    push_word(20'h12345);
    wait_sig(0, 30, n);
    check("post_flush_frame", enc_data, 32'h01234567);

    // reset in the middle of GAP with words queued
    push_word(20'h55555);
    push_word(20'h66666);
    wait_sig(1, 30, n);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("gap_rst_fill",  32'(fill),          32'd0);
    check("gap_rst_ready", 32'(payload_ready), 32'd1);
    check("gap_rst_data",  enc_data,           32'h0);
    check("gap_rst_start", 32'(enc_start),     32'd0);
    check("gap_rst_sent",  32'(pkt_sent),      32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      payload_valid = 1'($urandom_range(0, 1));
      payload       = 20'($urandom);
      flush         = ($urandom_range(0, 63) == 0);
      enc_len       = $urandom_range(1, 6);
      enc_hold      = ($urandom_range(0, 7) == 0);
      rst_n         = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk); #1;
    payload_valid = 1'b0; flush = 1'b0; enc_hold = 1'b0; rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // GAP_CT = 0 instance
    check("g0_rst_ready", 32'(ready2), 32'd1);
    check("g0_rst_fill",  32'(fill2),  32'd0);
    check("g0_rst_start", 32'(start2), 32'd0);
    check("g0_rst_data",  data2,       32'h0);
    @(posedge clk); #1 rst2_n = 1'b1;
    @(posedge clk); #1 valid2 = 1'b1; payload2 = 20'h00001;
    @(posedge clk); #1 payload2 = 20'h00002;
    @(negedge clk);
    check("g0_start0", 32'(start2), 32'd1);
    check("g0_data0",  data2,       32'h00000101);
    @(posedge clk); #1 valid2 = 1'b0; avail2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 avail2 = 1'b1;
    @(negedge clk);
    check("g0_sent",       32'(sent2),  32'd1);
    check("g0_no_start",   32'(start2), 32'd0);
    check("g0_fill1",      32'(fill2),  32'd1);
    @(negedge clk);
    check("g0_restart",    32'(start2), 32'd1);
    check("g0_data1",      data2,       32'h10000212);
    check("g0_sent_clear", 32'(sent2),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
